// File: rtl/sub_array_pkg.sv
// Shared types and index helpers for the sub-array streamer and its unpacker counterpart.
// The flat order lists region A (rows below SUB_ROWS) column-major, then region B column-major.
package sub_array_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   typedef struct packed {
      logic [15:0] row;
      logic [15:0] col;
   } rc_t;

   function automatic rc_t flat_to_rc(input int k, input int rows, input int cols,
                                      input int sub_rows);
      rc_t rc;
      int  kk;
      int  nb;
      rc = '0;
      kk = 0;
      nb = rows - sub_rows;
      if (k < cols * sub_rows) begin
         rc.row = 16'(k % sub_rows);
         rc.col = 16'(k / sub_rows);
      end else begin
         kk = k - cols * sub_rows;
         if (nb > 0) begin
            rc.row = 16'(sub_rows + (kk % nb));
            rc.col = 16'(kk / nb);
         end
      end
      return rc;
   endfunction

   function automatic int nbeats(input int rows, input int cols, input int beat_elems);
      return (rows * cols) / beat_elems;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sub_array_beat_mux.sv
// Combinational beat selector: wires every beat of the stored matrix in flat order
// at elaboration time, then picks one beat by beat_cnt.
module sub_array_beat_mux
   import sub_array_pkg::*;
#(
   parameter int BIT_WIDTH  = 4,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int SUB_ROWS   = 4,
   parameter int BEAT_ELEMS = 8
) (
   input  logic [BIT_WIDTH-1:0]            mat [ROWS][COLS],
   input  logic [cnt_width(nbeats(ROWS, COLS, BEAT_ELEMS))-1:0] beat_cnt,
   output logic [BEAT_ELEMS*BIT_WIDTH-1:0] out_data
);

   localparam int NBEATS = nbeats(ROWS, COLS, BEAT_ELEMS);
   localparam int CNT_W  = cnt_width(NBEATS);

   logic [BEAT_ELEMS*BIT_WIDTH-1:0] beats [NBEATS];

   // Flat index is a constant per (beat, element), so the reorder is pure wiring.
   for (genvar b = 0; b < NBEATS; b++) begin : g_beat
      for (genvar e = 0; e < BEAT_ELEMS; e++) begin : g_elem
         localparam rc_t RC = flat_to_rc(b * BEAT_ELEMS + e, ROWS, COLS, SUB_ROWS);
         localparam int  R  = int'(RC.row);
         localparam int  C  = int'(RC.col);
         assign beats[b][e*BIT_WIDTH +: BIT_WIDTH] = mat[R][C];
      end
   end

   always_comb begin
      out_data = '0;
      for (int b = 0; b < NBEATS; b++) begin
         if (beat_cnt == CNT_W'(b)) out_data = beats[b];
      end
   end

endmodule

// File: rtl/convert_3d_to_1d_sub_array_streamer.sv
// Captures a ROWS x COLS matrix and streams it in sub-array flat order, BEAT_ELEMS per beat.
// Optional out_parity port when CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN is defined.
module convert_3d_to_1d_sub_array_streamer
   import sub_array_pkg::*;
#(
   parameter int BIT_WIDTH  = 4,
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int SUB_ROWS   = 4,
   parameter int BEAT_ELEMS = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [BIT_WIDTH-1:0]            in_mat [ROWS][COLS],
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [BEAT_ELEMS*BIT_WIDTH-1:0] out_data,
   output logic                            out_last
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
   ,
   output logic                            out_parity
`endif
);

   localparam int               NBEATS    = nbeats(ROWS, COLS, BEAT_ELEMS);
   localparam int               CNT_W     = cnt_width(NBEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

   if ((BEAT_ELEMS <= 0) || ((ROWS * COLS) % BEAT_ELEMS != 0)) begin : g_bad_beat
      $fatal(1, "ROWS*COLS must be divisible by BEAT_ELEMS");
   end
   if ((SUB_ROWS < 0) || (SUB_ROWS > ROWS)) begin : g_bad_sub
      $fatal(1, "SUB_ROWS must lie in 0..ROWS");
   end

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   capture;
   logic [BIT_WIDTH-1:0]   mat_q [ROWS][COLS];

   // in_ready sees out_ready combinationally so a new matrix can load on the last beat.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      out_valid = 1'b0;
      out_last  = 1'b0;
      in_ready  = 1'b0;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         SEND: begin
            out_valid = 1'b1;
            out_last  = (cnt_q == LAST_BEAT);
            in_ready  = out_last && out_ready;
            if (out_ready) begin
               if (out_last) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      capture = in_valid && in_ready;
      if (capture) begin
         state_d = SEND;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               mat_q[r][c] <= '0;
            end
         end
      end else if (capture) begin
         mat_q <= in_mat;
      end
   end

   sub_array_beat_mux #(
      .BIT_WIDTH  (BIT_WIDTH),
      .ROWS       (ROWS),
      .COLS       (COLS),
      .SUB_ROWS   (SUB_ROWS),
      .BEAT_ELEMS (BEAT_ELEMS)
   ) u_mux (
      .mat      (mat_q),
      .beat_cnt (cnt_q),
      .out_data (out_data)
   );

`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
   // Matrix register clears on reset, so parity reads 0 then as well.
   assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_convert_3d_to_1d_sub_array_streamer.sv
// Scoreboard bench for convert_3d_to_1d_sub_array_streamer: main 8x8 instance plus
// SUB_ROWS=0, SUB_ROWS=8 and 2x2 single-beat instances.
module tb_convert_3d_to_1d_sub_array_streamer;

   typedef struct {
      logic [63:0] d;
      logic        l;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // main instance
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_mat [8][8];
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;
   logic        out_last;
   // degenerate-region instances share in_mat
   logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, out_last_a, out_last_b;
   logic [63:0] out_data_a, out_data_b;
   // 2x2 single-beat instance
   logic        in_valid2 = 1'b0;
   logic        in_ready2, out_valid2, out_last2;
   logic [7:0]  in_mat2 [2][2];
   logic [31:0] out_data2;
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
   logic        out_parity, par_a, par_b, par2;
`endif

   exp_t        q_main[$];
   exp_t        qa[$];
   exp_t        qb[$];
   exp_t        q2[$];
   logic [63:0] bt [8];
   bit          rdy_rand = 1'b0;

   convert_3d_to_1d_sub_array_streamer #(
      .BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(4), .BEAT_ELEMS(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mat(in_mat),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
      , .out_parity(out_parity)
`endif
   );

   convert_3d_to_1d_sub_array_streamer #(
      .BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(0), .BEAT_ELEMS(8)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_mat(in_mat),
      .out_valid(out_valid_a), .out_ready(1'b1), .out_data(out_data_a), .out_last(out_last_a)
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
      , .out_parity(par_a)
`endif
   );

   convert_3d_to_1d_sub_array_streamer #(
      .BIT_WIDTH(8), .ROWS(8), .COLS(8), .SUB_ROWS(8), .BEAT_ELEMS(8)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_mat(in_mat),
      .out_valid(out_valid_b), .out_ready(1'b1), .out_data(out_data_b), .out_last(out_last_b)
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
      , .out_parity(par_b)
`endif
   );

   convert_3d_to_1d_sub_array_streamer #(
      .BIT_WIDTH(8), .ROWS(2), .COLS(2), .SUB_ROWS(1), .BEAT_ELEMS(4)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_mat(in_mat2),
      .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .out_last(out_last2)
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
      , .out_parity(par2)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference order: walk region A column by column, then region B column by column.
   function automatic void build(input int sr);
      logic [7:0] flat[$];
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < sr; r++) flat.push_back(in_mat[r][c]);
      for (int c = 0; c < 8; c++)
         for (int r = sr; r < 8; r++) flat.push_back(in_mat[r][c]);
      for (int b = 0; b < 8; b++) begin
         bt[b] = '0;
         for (int e = 0; e < 8; e++) bt[b][e*8 +: 8] = flat[b*8 + e];
      end
   endfunction

   task automatic fill(input logic [7:0] base);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) in_mat[r][c] = base + 8'(r * 16 + c);
   endtask

   task automatic send_main();
      bit ok = 1'b0;
      build(4);
      for (int b = 0; b < 8; b++) q_main.push_back('{d: bt[b], l: (b == 7)});
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("m_accept", 64'(ok), 1);
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 600 && !done; i++) begin
         if (q_main.size() + qa.size() + qb.size() + q2.size() == 0 &&
             !out_valid && !out_valid_a && !out_valid_b && !out_valid2) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("drain", 64'(done), 1);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // main monitor: ordering, continuity, hold under stall, in_ready rule
   initial begin
      bit          pc, pg, sv;
      logic [63:0] hd;
      logic        hl;
      exp_t        e;
      pc = 0; pg = 0; sv = 0; hd = '0; hl = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pc = 0; pg = 0; sv = 0;
         end else begin
            if (pc || pg || sv) chk("m_valid_cont", 64'(out_valid), 1);
            if (sv && out_valid) begin
               chk("m_hold_data", out_data, hd);
               chk("m_hold_last", 64'(out_last), 64'(hl));
            end
            if (out_valid) begin
               chk("m_in_ready_send", 64'(in_ready), 64'(out_last && out_ready));
               if (out_ready) begin
                  sv = 0;
                  chk("m_beat_expected", 64'(q_main.size() > 0), 1);
                  if (q_main.size() > 0) begin
                     e = q_main.pop_front();
                     chk("m_data", out_data, e.d);
                     chk("m_last", 64'(out_last), 64'(e.l));
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
                     chk("m_parity", 64'(out_parity), 64'(^e.d));
`endif
                  end
               end else begin
                  sv = 1; hd = out_data; hl = out_last;
               end
            end else begin
               chk("m_in_ready_idle", 64'(in_ready), 1);
            end
            pc = in_valid && in_ready;
            pg = out_valid && out_ready && !out_last;
         end
      end
   end

   // side-instance monitors (out_ready tied high)
   initial begin
      exp_t e;
      bit   pc2 = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (out_valid_a) begin
               chk("a_beat_expected", 64'(qa.size() > 0), 1);
               if (qa.size() > 0) begin
                  e = qa.pop_front();
                  chk("a_data", out_data_a, e.d);
                  chk("a_last", 64'(out_last_a), 64'(e.l));
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
                  chk("a_parity", 64'(par_a), 64'(^e.d));
`endif
               end
            end
            if (out_valid_b) begin
               chk("b_beat_expected", 64'(qb.size() > 0), 1);
               if (qb.size() > 0) begin
                  e = qb.pop_front();
                  chk("b_data", out_data_b, e.d);
                  chk("b_last", 64'(out_last_b), 64'(e.l));
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
                  chk("b_parity", 64'(par_b), 64'(^e.d));
`endif
               end
            end
            if (pc2) chk("s_valid_cont", 64'(out_valid2), 1);
            if (out_valid2) begin
               chk("s_beat_expected", 64'(q2.size() > 0), 1);
               if (q2.size() > 0) begin
                  e = q2.pop_front();
                  chk("s_data", 64'(out_data2), e.d);
                  chk("s_last", 64'(out_last2), 64'(e.l));
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
                  chk("s_parity", 64'(par2), 64'(^e.d));
`endif
               end
            end
            pc2 = in_valid2 && in_ready2;
         end else pc2 = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      fill(8'h00);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) in_mat2[r][c] = 8'h00;
      #1 rst_n = 1'b0;
      #3;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_out_last", 64'(out_last), 0);
      chk("rst_out_data", out_data, 0);
`ifdef CONVERT_3D_TO_1D_SUB_ARRAY_PARITY_EN
      chk("rst_parity", 64'(out_parity), 0);
`endif
      #18 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic order, out_ready held high
      fill(8'h00);
      send_main();
      wait_drain();

      // random backpressure
      rdy_rand = 1'b1;
      send_main();
      wait_drain();

      // back-to-back, with and without backpressure
      for (int m = 0; m < 2; m++) begin
         rdy_rand = (m == 1);
         fill(8'h00);
         send_main();
         fill(8'h80);
         send_main();
         wait_drain();
      end
      rdy_rand = 1'b0;
      @(posedge clk);
      #1;

      // reset while beat 3 is on the bus
      fill(8'h00);
      send_main();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 0);
      chk("mid_rst_in_ready", 64'(in_ready), 1);
      chk("mid_rst_out_last", 64'(out_last), 0);
      chk("mid_rst_out_data", out_data, 0);
      q_main.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      fill(8'h08);
      send_main();
      wait_drain();

      // parity pattern: all 0x01, then one element 0x03
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) in_mat[r][c] = 8'h01;
      send_main();
      wait_drain();
      in_mat[5][2] = 8'h03;
      send_main();
      wait_drain();

      // degenerate regions
      fill(8'h00);
      build(0);
      for (int b = 0; b < 8; b++) qa.push_back('{d: bt[b], l: (b == 7)});
      build(8);
      for (int b = 0; b < 8; b++) qb.push_back('{d: bt[b], l: (b == 7)});
      in_valid_a = 1'b1;
      in_valid_b = 1'b1;
      @(negedge clk);
      chk("a_in_ready", 64'(in_ready_a), 1);
      chk("b_in_ready", 64'(in_ready_b), 1);
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      wait_drain();

      // 2x2 single beat, back-to-back on consecutive cycles
      in_mat2[0][0] = 8'h11; in_mat2[0][1] = 8'h12;
      in_mat2[1][0] = 8'h21; in_mat2[1][1] = 8'h22;
      q2.push_back('{d: 64'h22211211, l: 1'b1});
      in_valid2 = 1'b1;
      @(negedge clk);
      chk("s_in_ready_idle", 64'(in_ready2), 1);
      @(posedge clk);
      #1;
      in_mat2[0][0] = 8'h33; in_mat2[0][1] = 8'h34;
      in_mat2[1][0] = 8'h43; in_mat2[1][1] = 8'h44;
      q2.push_back('{d: 64'h44433433, l: 1'b1});
      @(negedge clk);
      chk("s_in_ready_b2b", 64'(in_ready2), 1);
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      wait_drain();

      chk("queues_empty", 64'(q_main.size() + qa.size() + qb.size() + q2.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
